// File: rtl/ysyx_22050039_idu_pipe.sv
// RV64 decode stage: GPR file, busy scoreboard, hazard stall,
// writeback bypass and a registered valid/ready output bundle.
module ysyx_22050039_idu_pipe #(
    parameter int XLEN     = 64,
    parameter int INST_LEN = 32,
    parameter int NR_REG   = 32,
    parameter int REG_SEL  = 5,
    parameter int FUNC_LEN = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [INST_LEN-1:0] in_inst,
    input  logic [XLEN-1:0]     in_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_pc,
    output logic [XLEN-1:0]     out_src1,
    output logic [XLEN-1:0]     out_src2,
    output logic [XLEN-1:0]     out_imm,
    output logic [REG_SEL-1:0]  out_rd,
    output logic [FUNC_LEN-1:0] out_func,
    output logic                out_wreg,
    output logic                out_wpc,
    input  logic                wb_en,
    input  logic [REG_SEL-1:0]  wb_rd,
    input  logic [XLEN-1:0]     wb_data,
    input  logic                flush,
    output logic [NR_REG-1:0]   busy_vec
);

    localparam logic [FUNC_LEN-1:0] F_INV    = FUNC_LEN'(0);
    localparam logic [FUNC_LEN-1:0] F_ADDI   = FUNC_LEN'(1);
    localparam logic [FUNC_LEN-1:0] F_JALR   = FUNC_LEN'(2);
    localparam logic [FUNC_LEN-1:0] F_AUIPC  = FUNC_LEN'(3);
    localparam logic [FUNC_LEN-1:0] F_LUI    = FUNC_LEN'(4);
    localparam logic [FUNC_LEN-1:0] F_SD     = FUNC_LEN'(5);
    localparam logic [FUNC_LEN-1:0] F_JAL    = FUNC_LEN'(6);
    localparam logic [FUNC_LEN-1:0] F_EBREAK = FUNC_LEN'(7);
    localparam logic [FUNC_LEN-1:0] F_ADD    = FUNC_LEN'(8);
    localparam logic [FUNC_LEN-1:0] F_BEQ    = FUNC_LEN'(9);

    typedef enum logic [2:0] {T_N, T_R, T_I, T_S, T_B, T_U, T_J} fmt_e;

    logic [XLEN-1:0]     gpr [NR_REG];
    logic [NR_REG-1:0]   busy_q, busy_nxt, busy_eff, wb_hit;
    logic [6:0]          opc, f7;
    logic [2:0]          f3;
    logic [REG_SEL-1:0]  rs1, rs2, rd;
    logic [FUNC_LEN-1:0] func;
    fmt_e                fmt;
    logic [XLEN-1:0]     imm, rv1, rv2, src1, src2;
    logic                use1, use2, wreg, wpc, hazard, accept;

    assign opc = in_inst[6:0];
    assign rd  = in_inst[11:7];
    assign f3  = in_inst[14:12];
    assign rs1 = in_inst[19:15];
    assign rs2 = in_inst[24:20];
    assign f7  = in_inst[31:25];

    // Opcode match to func code and encoding format
    always_comb begin
        func = F_INV;
        fmt  = T_N;
        unique case (1'b1)
            in_inst == 32'h0010_0073: func = F_EBREAK;
            opc == 7'b0010011 && f3 == 3'b000: begin func = F_ADDI; fmt = T_I; end
            opc == 7'b1100111 && f3 == 3'b000: begin func = F_JALR; fmt = T_I; end
            opc == 7'b0010111: begin func = F_AUIPC; fmt = T_U; end
            opc == 7'b0110111: begin func = F_LUI; fmt = T_U; end
            opc == 7'b0100011 && f3 == 3'b011: begin func = F_SD; fmt = T_S; end
            opc == 7'b1101111: begin func = F_JAL; fmt = T_J; end
            opc == 7'b0110011 && f3 == 3'b000 && f7 == 7'b0: begin func = F_ADD; fmt = T_R; end
            opc == 7'b1100011 && f3 == 3'b000: begin func = F_BEQ; fmt = T_B; end
            default: ;
        endcase
    end

    // Immediate extraction and sign extension
    always_comb begin
        imm = '0;
        case (fmt)
            T_I: imm = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
            T_S: imm = {{(XLEN-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            T_B: imm = {{(XLEN-13){in_inst[31]}}, in_inst[31], in_inst[7],
                        in_inst[30:25], in_inst[11:8], 1'b0};
            T_U: imm = {{(XLEN-32){in_inst[31]}}, in_inst[31:12], 12'b0};
            T_J: imm = {{(XLEN-21){in_inst[31]}}, in_inst[31], in_inst[19:12],
                        in_inst[20], in_inst[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

    // Register read with same-cycle writeback bypass, x0 reads zero
    always_comb begin
        rv1 = gpr[rs1];
        rv2 = gpr[rs2];
        if (wb_en && wb_rd == rs1) rv1 = wb_data;
        if (wb_en && wb_rd == rs2) rv2 = wb_data;
        if (rs1 == '0) rv1 = '0;
        if (rs2 == '0) rv2 = '0;
    end

    // Operand selection, write flags and hazard detection
    always_comb begin
        src1 = '0;
        src2 = '0;
        case (fmt)
            T_R, T_S, T_B: begin src1 = rv1; src2 = rv2; end
            T_I: begin src1 = rv1; src2 = imm; end
            T_U, T_J: begin src1 = imm; src2 = in_pc; end
            default: ;
        endcase
        use1 = fmt inside {T_R, T_I, T_S, T_B};
        use2 = fmt inside {T_R, T_S, T_B};
        wreg = (func inside {F_ADDI, F_JALR, F_AUIPC, F_LUI, F_JAL, F_ADD}) && rd != '0;
        wpc  = func inside {F_JALR, F_JAL, F_BEQ};
        wb_hit   = wb_en ? (NR_REG'(1) << wb_rd) : '0;
        busy_eff = busy_q & ~wb_hit;
        hazard   = (use1 && busy_eff[rs1]) || (use2 && busy_eff[rs2]) || (wreg && busy_eff[rd]);
    end

    assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
    assign accept   = in_valid && in_ready;
    assign busy_vec = busy_q;

    // Scoreboard next state: clears first so a same-cycle set wins
    always_comb begin
        busy_nxt = busy_q;
        if (wb_en && wb_rd != '0) busy_nxt[wb_rd] = 1'b0;
        if (flush && out_valid && out_wreg) busy_nxt[out_rd] = 1'b0;
        if (accept && wreg) busy_nxt[rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    // GPR file write port; x0 is never written
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NR_REG; i++) gpr[i] <= '0;
        end else if (wb_en && wb_rd != '0) begin
            gpr[wb_rd] <= wb_data;
        end
    end

    // Scoreboard and output bundle register
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q    <= '0;
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_src1  <= '0;
            out_src2  <= '0;
            out_imm   <= '0;
            out_rd    <= '0;
            out_func  <= '0;
            out_wreg  <= 1'b0;
            out_wpc   <= 1'b0;
        end else begin
            busy_q <= busy_nxt;
            if (flush) out_valid <= 1'b0;
            else if (accept) out_valid <= 1'b1;
            else if (out_ready) out_valid <= 1'b0;
            if (accept) begin
                out_pc   <= in_pc;
                out_src1 <= src1;
                out_src2 <= src2;
                out_imm  <= imm;
                out_rd   <= rd;
                out_func <= func;
                out_wreg <= wreg;
                out_wpc  <= wpc;
            end
        end
    end

endmodule
